fft_frame_unpacker: RTL
=======================

# fft_frame_unpacker

Receive-side partner of the 4x4 transpose buffer. Accepts the buffer's 136-bit, 4-lane beat stream (four 34-bit complex samples per beat, four beats per frame, no backpressure) and re-serialises each 16-sample frame into one sample per cycle with valid/ready and frame markers. Sits between the transpose stage and the next single-sample consumer (butterfly stage or output port). Ping-pong banking lets one frame drain while the next fills.

## Interface
- SAMPLE_W, 34, width of one complex sample (17-bit re in upper half, 17-bit im in lower half; carried opaquely)
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- data_in  in  4*SAMPLE_W  beat; lane L occupies [SAMPLE_W*(L+1)-1 : SAMPLE_W*L]
- in_flag  in  1  beat strobe; data_in sampled on every clk where high
- dout  out  SAMPLE_W  current sample; 0 when dout_valid low
- dout_valid  out  1  sample available
- dout_ready  in  1  downstream accepts; transfer = dout_valid & dout_ready
- dout_sof  out  1  high with sample index 0 of a frame (qualified by dout_valid)
- dout_eof  out  1  high with sample index 15 of a frame (qualified by dout_valid)
- overflow  out  1  sticky: a beat arrived for a bank still holding an undrained frame

## Operation
- Single clock domain. Reset is synchronous, active-low (rst_n sampled on rising clk).
- Input beat counter (2 bits) advances on every in_flag beat, wraps 3->0; beats 0..3 form one frame. Counter advances even when a beat is dropped, preserving frame alignment.
- Two banks of 16 x SAMPLE_W. wr_bank selects filling bank; toggles after beat 3. rd_bank selects draining bank; toggles after sample 15 transferred. Both reset to bank 0.
- Beat b, lane L stored at sample index n = 4*b + L. Output order is n = 0..15.
- bank_full[k] set on the edge that writes beat 3 into bank k; cleared on the edge that transfers sample 15 of bank k.
- Beat arriving while bank_full[wr_bank] is 1 and not being cleared that same cycle: beat discarded (bank contents unchanged), overflow set, stays 1 until reset.
- Simultaneous: sample 15 of bank k transfers in the same cycle a beat targets bank k -> beat accepted, no overflow.
- dout_valid = bank_full[rd_bank]. Read index (4 bits) advances only on transfer; holds under dout_ready low; dout/dout_sof/dout_eof stable while stalled.
- Reset mid-frame: partial input frame and any undrained frame abandoned; counters, bank_full, overflow cleared; first beat after reset is beat 0.

## Timing
- Reset values: dout=0, dout_valid=0, dout_sof=0, dout_eof=0, overflow=0.
- Latency: beat 3 sampled at edge E -> dout_valid=1, dout=sample 0, dout_sof=1 in cycle after E.
- With dout_ready held high: 16 consecutive cycles of valid per frame, one sample per cycle.
- Sustained throughput without overflow: one frame per 16 cycles (upstream emits 4 beats per frame, so up to 12 idle cycles of margin per frame).
- Back-to-back frames: if second bank already full when first finishes draining, dout_valid stays high across the boundary (sample 15 then next frame's sample 0 on consecutive cycles).
- overflow asserts in cycle after offending beat edge.
- All outputs driven from registers or a mux on registered state; no combinational path from data_in/in_flag to outputs; dout_ready affects only next-state.

## Structure
- Shared package fft_pkg: SAMPLE_W=34, LANES=4, BEAT_W=LANES*SAMPLE_W, FRAME_LEN=16 (other FFT blocks use the same constants).
- Sub-module fft_frame_bank: one 16 x SAMPLE_W bank with beat write port (we, beat index, 4*SAMPLE_W data) and sample read port (4-bit index -> SAMPLE_W). Instantiated twice; top holds counters, bank_full, handshake and overflow.

## Test plan
- Reset then 4 beats, lane value = 16*b... i.e. sample n carries value n (beat0=={3,2,1,0}), ready=1 -> dout 0..15 on 16 consecutive cycles, sof with 0, eof with 15, first valid one cycle after beat 3.
- Same frame, dout_ready toggled 1,0,0,1,... -> each sample held stable while stalled, all 16 delivered once in order, no duplicates.
- Two frames (values 0..15, 100..115) beats on 8 consecutive cycles, ready=1 -> 32 contiguous valid samples 0..15,100..115, overflow=0.
- Three frames back-to-back with dout_ready=0 -> frames 1,2 retained, frame 3 beats dropped, overflow=1 after first frame-3 beat; releasing ready yields frames 1,2 only.
- Frame 2 beat 0 arrives exactly in cycle sample 15 of bank 0 transfers (with bank 1 already full earlier) -> beat accepted, overflow=0.
- rst_n low for one cycle after beat 1 of a frame, then 4 fresh beats -> outputs all 0 during reset, next frame delivered intact from sample 0, overflow=0.

Source files
------------

// File: rtl/fft_pkg.sv
// Constants and types shared by the FFT datapath blocks.
// A beat carries LANES complex samples; a frame is FRAME_LEN samples.
package fft_pkg;
    localparam int SAMPLE_W   = 34;
    localparam int LANES      = 4;
    localparam int BEAT_W     = LANES * SAMPLE_W;
    localparam int FRAME_LEN  = 16;
    localparam int BEATS      = FRAME_LEN / LANES;
    localparam int IDX_W      = $clog2(FRAME_LEN);
    localparam int BEAT_IDX_W = $clog2(BEATS);
    localparam int BANKS      = 2;

    typedef logic [SAMPLE_W-1:0]   sample_t;
    typedef logic [BEAT_W-1:0]     beat_t;
    typedef logic [IDX_W-1:0]      idx_t;
    typedef logic [BEAT_IDX_W-1:0] bidx_t;
endpackage

// File: rtl/fft_frame_unpacker_if.sv
// Beat-in / sample-out bus of the frame unpacker.
// The master side drives beats and ready; the slave side is the unpacker.
interface fft_frame_unpacker_if;
    import fft_pkg::*;

    beat_t   data_in;
    logic    in_flag;
    sample_t dout;
    logic    dout_valid;
    logic    dout_ready;
    logic    dout_sof;
    logic    dout_eof;
    logic    overflow;

    modport master (
        output data_in, in_flag, dout_ready,
        input  dout, dout_valid, dout_sof, dout_eof, overflow
    );

    modport slave (
        input  data_in, in_flag, dout_ready,
        output dout, dout_valid, dout_sof, dout_eof, overflow
    );
endinterface

// File: rtl/fft_frame_bank.sv
// One frame of storage: written a beat (LANES samples) at a time,
// read one sample at a time through an asynchronous index mux.
module fft_frame_bank
    import fft_pkg::*;
(
    input  logic    clk,
    input  logic    we,
    input  bidx_t   beat_idx,
    input  beat_t   wdata,
    input  idx_t    rd_idx,
    output sample_t rdata
);
    sample_t mem [FRAME_LEN];

    // Contents need no reset: a bank is only observed while marked full.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int l = 0; l < LANES; l++) begin
                mem[idx_t'(LANES * int'(beat_idx) + l)] <= wdata[l*SAMPLE_W +: SAMPLE_W];
            end
        end
    end

    assign rdata = mem[rd_idx];
endmodule

// File: rtl/fft_frame_unpacker.sv
// Ping-pong frame unpacker: 4-lane beats in, one sample per handshake out,
// with frame markers and a sticky overflow for beats landing on a full bank.
module fft_frame_unpacker
    import fft_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    fft_frame_unpacker_if.slave  bus
);
    localparam bidx_t LAST_BEAT   = bidx_t'(BEATS - 1);
    localparam idx_t  LAST_SAMPLE = idx_t'(FRAME_LEN - 1);

    bidx_t             beat_cnt;
    logic              wr_bank;
    logic              rd_bank;
    idx_t              rd_idx;
    logic [BANKS-1:0]  bank_full;
    logic [BANKS-1:0]  bank_we;
    logic [BANKS-1:0]  bank_set;
    logic [BANKS-1:0]  bank_clr;
    logic              ovf;
    logic              valid;
    logic              xfer;
    logic              last_xfer;
    logic              drop;
    sample_t           bank_rdata [BANKS];

    assign valid     = bank_full[rd_bank];
    assign xfer      = valid & bus.dout_ready;
    assign last_xfer = xfer && (rd_idx == LAST_SAMPLE);

    // A bank emptying this cycle may be refilled by a beat in the same cycle.
    always_comb begin
        bank_clr          = '0;
        bank_we           = '0;
        bank_clr[rd_bank] = last_xfer;
        drop              = bus.in_flag && bank_full[wr_bank] && !bank_clr[wr_bank];
        bank_we[wr_bank]  = bus.in_flag && !drop;
        bank_set          = bank_we & {BANKS{beat_cnt == LAST_BEAT}};
    end

    for (genvar k = 0; k < BANKS; k++) begin : g_bank
        fft_frame_bank u_bank (
            .clk      (clk),
            .we       (bank_we[k]),
            .beat_idx (beat_cnt),
            .wdata    (bus.data_in),
            .rd_idx   (rd_idx),
            .rdata    (bank_rdata[k])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_cnt  <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            rd_idx    <= '0;
            bank_full <= '0;
            ovf       <= 1'b0;
        end else begin
            // Beat counter and write bank advance even on dropped beats to keep alignment.
            if (bus.in_flag) begin
                beat_cnt <= beat_cnt + 1'b1;
                if (beat_cnt == LAST_BEAT) wr_bank <= ~wr_bank;
            end
            if (xfer) begin
                rd_idx <= rd_idx + 1'b1;
                if (rd_idx == LAST_SAMPLE) rd_bank <= ~rd_bank;
            end
            if (drop) ovf <= 1'b1;
            bank_full <= (bank_full & ~bank_clr) | bank_set;
        end
    end

    assign bus.dout_valid = valid;
    assign bus.dout       = valid ? bank_rdata[rd_bank] : '0;
    assign bus.dout_sof   = valid && (rd_idx == '0);
    assign bus.dout_eof   = valid && (rd_idx == LAST_SAMPLE);
    assign bus.overflow   = ovf;
endmodule
